// File: rtl/wb_dbus_sched.sv
// wb_dbus_sched: Wishbone data-bus peripheral scheduler; optional ACTIVE timeout via WB_DEC_TIMEOUT_EN
module wb_dbus_sched #(
  parameter int                  NSLAVE   = 4,
  parameter logic [8*NSLAVE-1:0] ADDR_MAP = {8'h70, 8'h60, 8'h50, 8'h40},
  parameter int                  TIMEOUT  = 255
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [31:0]            wb_adr,
  input  logic                   wb_cyc,
  input  logic                   wb_we,
  output logic                   wb_ack,
  output logic [31:0]            wb_rdt,
  output logic [NSLAVE-1:0]      s_cyc,
  input  logic [NSLAVE-1:0]      s_ack,
  input  logic [32*NSLAVE-1:0]   s_rdt,
  output logic [1:0]             err
);
  localparam int SW = NSLAVE > 1 ? $clog2(NSLAVE) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, RESPOND, HOLDOFF} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d, hit_idx;
  logic              hit;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_rdt_q, wb_rdt_d;
  logic [NSLAVE-1:0] s_cyc_q, s_cyc_d;
  logic [1:0]        err_q, err_d;
  logic              unused_cfg;
`ifdef WB_DEC_TIMEOUT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif
  assign unused_cfg = ^{wb_adr[23:0], 32'(TIMEOUT)};
  assign wb_ack = wb_ack_q;
  assign wb_rdt = wb_rdt_q;
  assign s_cyc  = s_cyc_q;
  assign err    = err_q;
  // Address decode: scan downwards so the lowest matching slot is the one kept
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--)
      if (wb_adr[31:24] == ADDR_MAP[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
  end
  // Next-state logic; outputs are derived from the next state so they register with it
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = err_q;
    wb_rdt_d = 32'h0;
`ifdef WB_DEC_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE:
        if (wb_cyc && hit) begin
          state_d = ACTIVE;
          sel_d   = hit_idx;
`ifdef WB_DEC_TIMEOUT_EN
          cnt_d   = 16'h0;
`endif
        end else if (wb_cyc) begin
          state_d  = RESPOND;
          err_d[0] = 1'b1;
        end
      ACTIVE:
        if (!wb_cyc) state_d = IDLE;
        else if (s_ack[sel_q]) begin
          state_d  = RESPOND;
          wb_rdt_d = wb_we ? 32'h0 : s_rdt[32*sel_q +: 32];
        end
`ifdef WB_DEC_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d  = RESPOND;
          err_d[1] = 1'b1;
        end else cnt_d = cnt_q + 16'd1;
`endif
      RESPOND: state_d = HOLDOFF;
      default: state_d = IDLE;
    endcase
    wb_ack_d = state_d == RESPOND;
    s_cyc_d  = state_d == ACTIVE ? NSLAVE'(1) << sel_d : '0;
  end
  // State and output registers, cleared asynchronously so reset aborts any transaction
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      wb_ack_q <= 1'b0;
      wb_rdt_q <= 32'h0;
      s_cyc_q  <= '0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wb_ack_q <= wb_ack_d;
      wb_rdt_q <= wb_rdt_d;
      s_cyc_q  <= s_cyc_d;
      err_q    <= err_d;
    end
  end
`ifdef WB_DEC_TIMEOUT_EN
  // Wait-cycle counter for the hung-peripheral timeout
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) cnt_q <= 16'h0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule
